// File: rtl/scroll_word_display.sv
// Scrolling-message driver for a bank of active-low 7-segment digits.
// A NUM_DISP-wide window slides over MSG under a prescaled timebase with run/pause, direction, step and home.
module scroll_word_display #(
    parameter int                   NUM_DISP = 6,
    parameter int                   MSG_LEN  = 8,
    parameter int                   TICK_DIV = 50000000,
    parameter logic [3*MSG_LEN-1:0] MSG      = 24'hFFB488
) (
    input  logic                       CLOCK_50,
    input  logic                       Resetn,
    input  logic                       run_sw,
    input  logic                       dir_sw,
    input  logic                       step_key,
    input  logic                       home_key,
    output logic [7*NUM_DISP-1:0]      hex_out,
    output logic [$clog2(MSG_LEN)-1:0] offset,
    output logic                       running
);
    // state    | meaning
    // ST_PAUSE | window frozen; step_key advances it by one
    // ST_RUN   | prescaler running; every TICK_DIV clocks the window advances
    typedef enum logic {ST_PAUSE, ST_RUN} state_t;

    localparam int OW = $clog2(MSG_LEN);
    localparam int CW = $clog2(TICK_DIV);

    logic r_run_meta, r_run_s, r_dir_meta, r_dir_s;
    logic r_step_meta, r_step_s, r_step_d;
    logic r_home_meta, r_home_s, r_home_d;
    state_t r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [OW-1:0] r_offset;
    logic [7*NUM_DISP-1:0] r_hex, w_hex;
    logic w_step_p, w_home_p, w_tc, w_tick, w_adv;
    int w_idx;

    function automatic logic [6:0] f_glyph(input logic [2:0] code);
        case (code)
            3'd0:    f_glyph = 7'h09;
            3'd1:    f_glyph = 7'h06;
            3'd2:    f_glyph = 7'h47;
            3'd3:    f_glyph = 7'h40;
            3'd4:    f_glyph = 7'h0C;
            3'd5:    f_glyph = 7'h03;
            3'd6:    f_glyph = 7'h21;
            default: f_glyph = 7'h7F;
        endcase
    endfunction

    // Keys idle high, so their synchronisers reset to the released level.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_run_meta  <= 1'b0;
            r_run_s     <= 1'b0;
            r_dir_meta  <= 1'b0;
            r_dir_s     <= 1'b0;
            r_step_meta <= 1'b1;
            r_step_s    <= 1'b1;
            r_step_d    <= 1'b1;
            r_home_meta <= 1'b1;
            r_home_s    <= 1'b1;
            r_home_d    <= 1'b1;
        end else begin
            r_run_meta  <= run_sw;
            r_run_s     <= r_run_meta;
            r_dir_meta  <= dir_sw;
            r_dir_s     <= r_dir_meta;
            r_step_meta <= step_key;
            r_step_s    <= r_step_meta;
            r_step_d    <= r_step_s;
            r_home_meta <= home_key;
            r_home_s    <= r_home_meta;
            r_home_d    <= r_home_s;
        end
    end

    assign w_step_p = r_step_d & ~r_step_s;
    assign w_home_p = r_home_d & ~r_home_s;

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) r_state <= ST_PAUSE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_PAUSE: if (r_run_s)  w_state_nxt = ST_RUN;
            ST_RUN:   if (!r_run_s) w_state_nxt = ST_PAUSE;
            default:  w_state_nxt = ST_PAUSE;
        endcase
    end

    // A tick is suppressed in the cycle that leaves RUN, so pausing never emits a step.
    assign w_tc   = (r_cnt == CW'(TICK_DIV - 1));
    assign w_tick = (r_state == ST_RUN) && r_run_s && w_tc;
    assign w_adv  = w_tick || ((r_state == ST_PAUSE) && w_step_p);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn)                              r_cnt <= '0;
        else if ((r_state == ST_RUN) && r_run_s)  r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
        else                                      r_cnt <= '0;
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_offset <= '0;
        end else if (w_home_p) begin
            r_offset <= '0;
        end else if (w_adv) begin
            if (!r_dir_s) r_offset <= (r_offset == OW'(MSG_LEN - 1)) ? '0 : r_offset + OW'(1);
            else          r_offset <= (r_offset == '0) ? OW'(MSG_LEN - 1) : r_offset - OW'(1);
        end
    end

    always_comb begin
        w_hex = '1;
        w_idx = 0;
        for (int d = 0; d < NUM_DISP; d++) begin
            w_idx = (int'(r_offset) + d) % MSG_LEN;
            w_hex[7*(NUM_DISP-d)-1 -: 7] = f_glyph(MSG[3*w_idx +: 3]);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) r_hex <= '1;
        else         r_hex <= w_hex;
    end

    assign hex_out = r_hex;
    assign offset  = r_offset;
    assign running = (r_state == ST_RUN);
endmodule
